// File: rtl/cla_multiword_adder.sv
// rtl/cla_multiword_adder.sv - multi-word adder sequenced through one 5-bit carry-lookahead adder
//
// carryLookAheadAdder: 5-bit carry-lookahead adder
//   a, b  in  5  addends
//   cin   in  1  carry in
//   sum   out 5  a + b + cin, low 5 bits
//   cout  out 1  carry out of bit 4
//
// cla_multiword_adder: adds two WORDS x 5-bit operands, least-significant word first,
// one word per clock, holding the inter-word carry in a register.
//   clk      in  1  clock, rising edge
//   rst      in  1  asynchronous active-high reset
//   start    in  1  request an addition (accepted in IDLE or DONE)
//   a_in     in  W  operand A, captured on an accepted start
//   b_in     in  W  operand B, captured on an accepted start
//   cin      in  1  carry into word 0, captured on an accepted start
//   busy     out 1  high while words are being added
//   done     out 1  one-cycle completion pulse
//   sum_out  out W  sum of the last completed addition
//   cout     out 1  carry out of the last completed addition
//   ovf      out 1  signed overflow of the last completed addition

module carryLookAheadAdder (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);

  logic [4:0] g;
  logic [4:0] p;
  logic [5:0] c;
  logic       term;

  // Each carry is the flattened lookahead sum of products: a generate at bit j
  // propagated through bits j+1..i-1, or cin propagated through all lower bits.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 1; i <= 5; i++) begin
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        c[i] = c[i] | term;
      end
      term = cin;
      for (int k = 0; k < i; k++) begin
        term = term & p[k];
      end
      c[i] = c[i] | term;
    end
    sum  = p ^ c[4:0];
    cout = c[5];
  end

endmodule

module cla_multiword_adder #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5*WORDS-1:0] a_in,
  input  logic [5*WORDS-1:0] b_in,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [5*WORDS-1:0] sum_out,
  output logic               cout,
  output logic               ovf
);

  localparam int W  = 5 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  work_sum;
  logic [W-1:0]  work_nxt;
  logic [W-1:0]  word_ext;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          sign_a;
  logic          sign_b;
  logic [4:0]    add_sum;
  logic          add_cout;
  logic          cnt_last;
  logic          accept;

  carryLookAheadAdder u_cla (
    .a    (a_sh[4:0]),
    .b    (b_sh[4:0]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign cnt_last = (cnt == CW'(WORDS - 1));
  assign accept   = start && (state != S_RUN);
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  // New word enters at the top while the partial sum moves down; after WORDS
  // cycles word 0 has reached the bottom. Written as shifts so WORDS=1 works.
  assign word_ext = W'(add_sum);
  assign work_nxt = (work_sum >> 5) | (word_ext << (W - 5));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      work_sum <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      sum_out  <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      a_sh     <= a_in;
      b_sh     <= b_in;
      work_sum <= '0;
      cnt      <= '0;
      carry    <= cin;
      sign_a   <= a_in[W-1];
      sign_b   <= b_in[W-1];
    end else if (state == S_RUN) begin
      a_sh     <= a_sh >> 5;
      b_sh     <= b_sh >> 5;
      work_sum <= work_nxt;
      carry    <= add_cout;
      cnt      <= cnt + 1'b1;
      if (cnt_last) begin
        sum_out <= work_nxt;
        cout    <= add_cout;
        ovf     <= (sign_a == sign_b) && (work_nxt[W-1] != sign_a);
      end
    end
  end

endmodule

// File: tb/tb_cla_multiword_adder.sv
// tb/tb_cla_multiword_adder.sv - self-checking bench for cla_multiword_adder

module tb_cla_multiword_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0;
  logic [19:0] a4 = '0;
  logic [19:0] b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4, ovf4;
  logic [19:0] sum4;

  logic        start1 = 1'b0;
  logic [4:0]  a1 = '0;
  logic [4:0]  b1 = '0;
  logic        cin1 = 1'b0;
  logic        busy1, done1, cout1, ovf1;
  logic [4:0]  sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_multiword_adder #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4), .ovf(ovf4)
  );

  cla_multiword_adder #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [19:0] a;
    logic [19:0] b;
    logic        c;
    logic [19:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit one, input logic [19:0] a, input logic [19:0] b, input logic c);
    if (one) begin
      start1 = 1'b1; a1 = a[4:0]; b1 = b[4:0]; cin1 = c;
    end else begin
      start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    end
  endtask

  task automatic clr_start();
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Counts negedges after the start edge; n0 is how many were already consumed.
  task automatic wait_done(input bit one, input int n0, output int lat,
                           output logic [19:0] s, output logic co, output logic ov);
    lat = -1;
    s = '0; co = 1'b0; ov = 1'b0;
    for (int n = n0 + 1; n <= n0 + 20 && lat < 0; n++) begin
      @(negedge clk);
      if (one ? done1 : done4) begin
        lat = n;
        s   = one ? {15'b0, sum1} : sum4;
        co  = one ? cout1 : cout4;
        ov  = one ? ovf1 : ovf4;
      end
    end
  endtask

  task automatic do_op(input bit one, input logic [19:0] a, input logic [19:0] b, input logic c,
                       output int lat, output logic [19:0] s, output logic co, output logic ov);
    @(negedge clk);
    drive(one, a, b, c);
    @(posedge clk);
    #1 clr_start();
    wait_done(one, 0, lat, s, co, ov);
  endtask

  function automatic logic ref_ovf(input int w, input logic [19:0] a, input logic [19:0] b, input logic c);
    longint as, bs, r, lim;
    lim = longint'(1) << (w - 1);
    as = longint'(a) & ((lim << 1) - 1);
    bs = longint'(b) & ((lim << 1) - 1);
    if (as >= lim) as = as - (lim << 1);
    if (bs >= lim) bs = bs - (lim << 1);
    r = as + bs + longint'(c);
    return (r >= lim) || (r < -lim);
  endfunction

  initial begin
    vec_t        vecs[$];
    int          lat;
    int          dcount;
    logic [19:0] s;
    logic        co, ov;
    logic [20:0] full;
    logic [19:0] ra, rb;
    logic        rc;

    vecs.push_back('{20'h00001, 20'h0001F, 1'b0, 20'h00020, 1'b0, 1'b0});
    vecs.push_back('{20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0});
    vecs.push_back('{20'h7FFFF, 20'h00000, 1'b1, 20'h80000, 1'b0, 1'b1});
    vecs.push_back('{20'h12345, 20'h54321, 1'b0, 20'h66666, 1'b0, 1'b0});
    vecs.push_back('{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1});
    vecs.push_back('{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0});
    vecs.push_back('{20'h40000, 20'h40000, 1'b0, 20'h80000, 1'b0, 1'b1});

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_sum", sum4, 20'h0);
    chk("reset_busy_done", {busy4, done4, cout4, ovf4}, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy4, done4}, 2'b00);

    // Directed table
    foreach (vecs[i]) begin
      do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].c, lat, s, co, ov);
      chk($sformatf("tbl%0d_lat", i), lat, 5);
      chk($sformatf("tbl%0d_sum", i), s, vecs[i].s);
      chk($sformatf("tbl%0d_cout", i), co, vecs[i].co);
      chk($sformatf("tbl%0d_ovf", i), ov, vecs[i].ov);
    end

    // start during RUN is ignored
    @(negedge clk);
    drive(1'b0, 20'h12345, 20'h54321, 1'b0);
    @(posedge clk);
    #1 clr_start();
    @(negedge clk);
    chk("run_busy", {busy4, done4}, 2'b10);
    @(negedge clk);
    drive(1'b0, 20'hFFFFF, 20'hFFFFF, 1'b1);
    @(posedge clk);
    #1 clr_start();
    wait_done(1'b0, 2, lat, s, co, ov);
    chk("ignore_lat", lat, 5);
    chk("ignore_sum", s, 20'h66666);
    chk("ignore_cout", co, 1'b0);

    // back-to-back: start held in DONE cycle
    drive(1'b0, 20'h00001, 20'h0001F, 1'b0);
    @(posedge clk);
    #1 clr_start();
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk($sformatf("b2b_hold%0d", n), {busy4, done4, sum4}, {2'b10, 20'h66666});
    end
    wait_done(1'b0, 4, lat, s, co, ov);
    chk("b2b_lat", lat, 5);
    chk("b2b_sum", s, 20'h00020);
    @(negedge clk);
    chk("done_single_cycle", done4, 1'b0);

    // asynchronous reset between edges with nonzero results held
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sum", sum4, 20'h0);
    chk("async_rst_flags", {busy4, done4, cout4, ovf4}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_async_rst", {busy4, done4}, 2'b00);

    // abort in the 2nd RUN cycle
    do_op(1'b0, 20'hFFFFF, 20'h00001, 1'b0, lat, s, co, ov);
    chk("pre_abort_cout", co, 1'b1);
    @(negedge clk);
    drive(1'b0, 20'h12345, 20'h54321, 1'b0);
    @(posedge clk);
    #1 clr_start();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {busy4, done4, cout4, ovf4, sum4}, 24'h0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done4) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    chk("abort_sum_zero", sum4, 20'h0);
    do_op(1'b0, 20'h12345, 20'h54321, 1'b1, lat, s, co, ov);
    chk("post_abort_lat", lat, 5);
    chk("post_abort_sum", s, 20'h66667);

    // random, WORDS=4
    for (int i = 0; i < 1000; i++) begin
      ra = 20'($urandom);
      rb = 20'($urandom);
      rc = 1'($urandom);
      do_op(1'b0, ra, rb, rc, lat, s, co, ov);
      full = {1'b0, ra} + {1'b0, rb} + {20'b0, rc};
      chk($sformatf("rnd4_%0d_lat", i), lat, 5);
      chk($sformatf("rnd4_%0d_sum", i), {co, s}, full);
      chk($sformatf("rnd4_%0d_ovf", i), ov, ref_ovf(20, ra, rb, rc));
    end

    // random, WORDS=1
    for (int i = 0; i < 200; i++) begin
      ra = 20'($urandom_range(0, 31));
      rb = 20'($urandom_range(0, 31));
      rc = 1'($urandom);
      do_op(1'b1, ra, rb, rc, lat, s, co, ov);
      full = {1'b0, ra} + {1'b0, rb} + {20'b0, rc};
      chk($sformatf("rnd1_%0d_lat", i), lat, 2);
      chk($sformatf("rnd1_%0d_sum", i), {co, s[4:0]}, full[5:0]);
      chk($sformatf("rnd1_%0d_ovf", i), ov, ref_ovf(5, ra, rb, rc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_multiword_adder.md
# cla_multiword_adder

Sequencer that sits directly upstream of the 5-bit `carryLookAheadAdder` and consumes its carry-out. It adds two wide operands of `WORDS` 5-bit words, least-significant word first, one word per clock, through a single `carryLookAheadAdder` instance. Between words the carry is held in a register. The block reports the wide sum, the final carry and a two's-complement overflow flag, with a start/done handshake.

## Interface
Parameters:
- `WORDS`, default 4: number of 5-bit words per operand. Operand width is W = 5*WORDS. Legal values are ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new addition. Sampled only in IDLE or DONE.
- `a_in`  in  W  operand A; captured on an accepted start.
- `b_in`  in  W  operand B; captured on an accepted start.
- `cin`  in  1  carry into word 0; captured on an accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; high while in DONE.
- `sum_out`  out  W  result of the last completed addition.
- `cout`  out  1  carry out of the top word of the last completed addition.
- `ovf`  out  1  signed overflow of the last completed addition.

## Operation
- State machine with three states: IDLE, RUN and DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE when word counter = WORDS-1.
  - DONE → RUN on `start`=1; DONE → IDLE otherwise.
  - `start` in RUN is ignored and is not queued.
- On an accepted start:
  - Load A and B into working shift registers `a_sh` and `b_sh`.
  - Set carry register ← `cin`.
  - Set word counter ← 0.
  - Clear the working sum register.
  - Latch the sign bits `a_in[W-1]` and `b_in[W-1]` for the overflow calculation.
- Each RUN cycle:
  - The adder instance adds `a_sh[4:0]` + `b_sh[4:0]` + carry register.
  - The 5-bit sum is shifted into the working sum from the top; the working sum shifts right by 5.
  - Carry register ← adder `cout`.
  - `a_sh` and `b_sh` shift right by 5.
  - Counter increments.
- On the RUN→DONE edge:
  - `sum_out` ← the completed working sum.
  - `cout` ← the final adder carry.
  - `ovf` ← (A sign == B sign) && (`sum_out[W-1]` != A sign).
- Result registers change only on the RUN→DONE edge. They hold their value through IDLE and through a following RUN, until the next completion.
- Arithmetic:
  - Unsigned modulo 2^W; {`cout`, `sum_out`} = A + B + `cin` exactly.
  - Counter width is max(1, clog2(WORDS)).
  - With WORDS=1 the block makes exactly one RUN cycle.
- Reset at any time, including mid-RUN:
  - State goes to IDLE; the operation is aborted.
  - `busy`=0, `done`=0, `sum_out`=0, `cout`=0, `ovf`=0; all internal registers are 0.
  - No `done` is produced for the aborted operation.

## Timing
- The adder path is combinational inside one cycle: adder plus carry register, with no extra pipeline.
- An accepted start at rising edge k gives:
  - RUN for cycles k+1 … k+WORDS, with `busy`=1.
  - `done`=1 in cycle k+WORDS+1, with `sum_out`, `cout` and `ovf` already valid in that cycle.
  - Latency from start edge to done is WORDS+1 cycles.
- Back-to-back operation: `start` held high in the DONE cycle enters RUN on the next edge. Throughput is one result per WORDS+1 cycles.
- `done` is never high for more than one consecutive cycle.
- `busy` and `done` are mutually exclusive.
- `a_in`, `b_in` and `cin` need be valid only in the cycle `start` is sampled. Later changes do not affect the operation in flight.

## Test plan
- Reset, WORDS=4: assert `rst` asynchronously between clock edges. All outputs must read 0 immediately, and the state must be IDLE after release.
- Carry across word boundary: `a_in`=0x00001, `b_in`=0x0001F, `cin`=0. Required: `sum_out`=0x00020, `cout`=0, `ovf`=0, with `done` exactly 5 cycles after the start edge.
- Full carry ripple: `a_in`=0xFFFFF, `b_in`=0x00001, `cin`=0. Required: `sum_out`=0x00000, `cout`=1, `ovf`=0. Also `a_in`=0x7FFFF, `b_in`=0x00000, `cin`=1. Required: `sum_out`=0x80000, `cout`=0, `ovf`=1.
- Handshake:
  - Pulse `start` during RUN with different operands; it must be ignored and the first result returned unchanged.
  - Hold `start` high in the DONE cycle; the next result must appear 5 cycles later, and `sum_out` must hold the old value meanwhile.
- Abort: assert `rst` in the 2nd RUN cycle. No `done` may occur and outputs must be 0. A fresh start after reset must complete normally.
- Random: 1000 random A, B and `cin` values at WORDS=4, plus a WORDS=1 build. Compare {`cout`, `sum_out`} against A+B+`cin`, and `ovf` against a signed reference model.
